// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: debounced run/step buttons and CPU halt request turned into a CPU clock enable and sequenced CPU reset.
// Define CYCLE_CNT_EN to add the saturating cycle_cnt output counting issued cpu_ce pulses.
module cpu_exec_ctrl #(
   parameter int DIV_RATIO = 12000000,
   parameter int DB_CYCLES = 240000,
   parameter int RST_HOLD  = 4,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_run_n,
   input  logic             btn_step_n,
   input  logic             halt_req,
   output logic             cpu_ce,
   output logic             cpu_rst_n,
   output logic [1:0]       state
`ifdef CYCLE_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt
`endif
);

   localparam int DIV_W = $clog2(DIV_RATIO);
   localparam int DB_W  = $clog2(DB_CYCLES);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATIO - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [3:0]       RST_LAST = 4'(RST_HOLD - 1);

   typedef enum logic [1:0] {
      ST_RESET = 2'b00,
      ST_HALT  = 2'b01,
      ST_RUN   = 2'b10,
      ST_STEP  = 2'b11
   } state_t;

   logic [1:0]           raw;
   logic [1:0]           sync_a;
   logic [1:0]           sync_b;
   logic [1:0]           level;
   logic [1:0]           press;
   logic [1:0][DB_W-1:0] db_cnt;
   logic                 run_p;
   logic                 step_p;

   state_t               cur_state;
   state_t               next_state;
   logic [DIV_W-1:0]     div;
   logic [DIV_W-1:0]     div_next;
   logic [3:0]           hold;
   logic [3:0]           hold_next;
   logic                 ce_next;

   // Bit 0 carries the run button, bit 1 the step button.
   assign raw    = {btn_step_n, btn_run_n};
   assign run_p  = press[0];
   assign step_p = press[1];
   assign state  = cur_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 2'b11;
         sync_b <= 2'b11;
         level  <= 2'b11;
         press  <= 2'b00;
         db_cnt <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         press  <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (sync_b[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i] <= '0;
               level[i]  <= sync_b[i];
               press[i]  <= ~sync_b[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= ST_RESET;
         div       <= '0;
         hold      <= '0;
         cpu_ce    <= 1'b0;
         cpu_rst_n <= 1'b0;
      end else begin
         cur_state <= next_state;
         div       <= div_next;
         hold      <= hold_next;
         cpu_ce    <= ce_next;
         cpu_rst_n <= (next_state != ST_RESET);
      end
   end

   // Divider sits at zero outside RUN, so entering RUN always starts a full period.
   always_comb begin
      next_state = cur_state;
      div_next   = '0;
      hold_next  = '0;
      ce_next    = 1'b0;
      case (cur_state)
         ST_RESET: begin
            if (hold == RST_LAST) begin
               next_state = ST_HALT;
            end else begin
               hold_next = hold + 1'b1;
            end
         end
         ST_HALT: begin
            if (run_p) begin
               next_state = ST_RUN;
            end else if (step_p) begin
               next_state = ST_STEP;
               ce_next    = 1'b1;
            end
         end
         ST_RUN: begin
            if (halt_req || run_p) begin
               next_state = ST_HALT;
            end else if (div == DIV_LAST) begin
               ce_next = 1'b1;
            end else begin
               div_next = div + 1'b1;
            end
         end
         default: begin
            next_state = ST_HALT;
         end
      endcase
   end

`ifdef CYCLE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
      end else if (cpu_ce && (cycle_cnt != '1)) begin
         cycle_cnt <= cycle_cnt + 1'b1;
      end
   end
`endif

endmodule
